instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-006 imem_addr  output  32  word-aligned fetch address, bits [1:0] always 0.
REQ-007 imem_rsp_valid  input  1  instruction word returned this cycle.
REQ-008 imem_rsp_data  input  32  returned instruction word.
REQ-009 redirect_valid  input  1  one-cycle pulse: branch/jump taken, refetch from redirect_pc.
REQ-010 redirect_pc  input  32  new fetch address (PC + generated B/J immediate).
REQ-011 Instr  output  32  registered instruction presented to decode and immediate generation.
REQ-012 instr_pc  output  32  address from which Instr was fetched.
REQ-013 instr_valid  output  1  Instr/instr_pc hold a live instruction.
REQ-014 instr_ready  input  1  decode consumes the instruction this cycle.
REQ-015 misaligned  output  1  one-cycle pulse: redirect_pc[1:0] was nonzero.

Function
REQ-016 FSM states: S_REQ, S_WAIT, S_HOLD, S_DROP; at most one memory request outstanding.
REQ-017 S_REQ: imem_req_valid=1, imem_addr=pc; on imem_req_ready go to S_WAIT.
REQ-018 S_WAIT: on imem_rsp_valid capture Instr<=imem_rsp_data, instr_pc<=pc, pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC->0), go to S_HOLD.
REQ-019 S_HOLD: instr_valid=1, Instr/instr_pc stable; on instr_ready go to S_REQ.
REQ-020 instr_valid SHALL be 1 exactly in S_HOLD; imem_req_valid exactly in S_REQ.
REQ-021 Latency with zero-wait memory: request cycle -> response next cycle -> instr_valid the cycle after; 3 cycles per instruction minimum.
REQ-022 redirect_valid in S_REQ without acceptance, or in S_HOLD: pc<=redirect_pc, go to S_REQ; in S_HOLD the held instruction is dropped (instr_valid low next cycle) even if instr_ready is high the same cycle.
REQ-023 redirect_valid in S_REQ with imem_req_ready high, or in S_WAIT without imem_rsp_valid: pc<=redirect_pc, go to S_DROP.
REQ-024 redirect_valid in S_WAIT with imem_rsp_valid high: response discarded, pc<=redirect_pc, go to S_REQ.
REQ-025 S_DROP: next imem_rsp_valid discarded (no capture), go to S_REQ; a further redirect updates pc and stays in S_DROP.
REQ-026 redirect_pc[1:0] forced to 00 when loaded; misaligned pulses the following cycle if they were nonzero.
REQ-027 imem_rsp_valid outside S_WAIT/S_DROP SHALL be ignored.

Reset
REQ-028 rst_n low: state<=S_REQ, pc<=RESET_PC, Instr<=0, instr_pc<=0, misaligned<=0, instr_valid=0, imem_req_valid=0 while rst_n low; asynchronous, mid-transaction any outstanding response is abandoned.
REQ-029 First request (imem_addr=RESET_PC) issued in the first cycle after rst_n rises.

Structure
REQ-030 Shared package: FSM state encoding, RESET_PC default, XLEN=32, instruction-step constant 4.
REQ-031 Single module, no sub-module; PC register, FSM and output register inline.

Verification
REQ-032 Reset, zero-wait memory returning 0x0000_0013 per word, instr_ready=1 -> instr_pc 0x0,0x4,0x8 each 3 cycles apart.
REQ-033 instr_ready held 0 for 5 cycles in S_HOLD -> Instr/instr_pc stable, no imem_req_valid until ready.
REQ-034 redirect_valid with redirect_pc=0x100 while in S_WAIT, response arrives 2 cycles later -> response dropped, next imem_addr=0x100, next instr_pc=0x100.
REQ-035 redirect_pc=0x202 in S_HOLD with instr_ready=1 -> misaligned pulses once, next imem_addr=0x200, held instruction not re-presented.
REQ-036 RESET_PC=0xFFFF_FFFC, one fetch -> next imem_addr=0x0000_0000.
REQ-037 rst_n asserted in S_WAIT, response arrives during reset -> no capture, after release imem_addr=RESET_PC, instr_valid=0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  // Instruction word plus the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: instruction memory request/response, redirect input and decode output.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] Instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic            misaligned;

  modport master (
    output imem_req_valid, imem_addr, Instr, instr_pc, instr_valid, misaligned,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, Instr, instr_pc, instr_valid, misaligned,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           instr_ready
  );

endinterface

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: PC register, fetch FSM and held
// instruction register, with branch/jump redirect and stale-response dropping.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic            clk,
  input logic            rst_n,
  instr_fetch_if.master  bus
);

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  fetch_pkt_t      held, held_n;
  logic            mis, mis_n;
  logic [XLEN-1:0] redirect_word;

  assign redirect_word = align_word(bus.redirect_pc);

  // Next-state, next-PC and capture logic.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    held_n  = held;
    mis_n   = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    case (state)
      S_REQ: begin
        if (bus.redirect_valid) begin
          pc_n = redirect_word;
          // An accepted request now returns a stale word that must be discarded.
          state_n = bus.imem_req_ready ? S_DROP : S_REQ;
        end else if (bus.imem_req_ready) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (bus.redirect_valid) begin
            pc_n    = redirect_word;
            state_n = S_REQ;
          end else begin
            held_n  = '{instr: bus.imem_rsp_data, pc: pc};
            pc_n    = pc + INSTR_STEP;
            state_n = S_HOLD;
          end
        end else if (bus.redirect_valid) begin
          pc_n    = redirect_word;
          state_n = S_DROP;
        end
      end
      S_HOLD: begin
        if (bus.redirect_valid) begin
          pc_n    = redirect_word;
          state_n = S_REQ;
        end else if (bus.instr_ready) begin
          state_n = S_REQ;
        end
      end
      S_DROP: begin
        if (bus.redirect_valid) begin
          pc_n = redirect_word;
        end
        // The stale word is the only one outstanding, so its arrival frees the bus.
        if (bus.imem_rsp_valid) begin
          state_n = S_REQ;
        end
      end
      default: state_n = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
      pc    <= align_word(RESET_PC);
      held  <= '0;
      mis   <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      held  <= held_n;
      mis   <= mis_n;
    end
  end

  // Request is qualified by rst_n so it stays low while reset is held.
  assign bus.imem_req_valid = (state == S_REQ) && rst_n;
  assign bus.imem_addr      = pc;
  assign bus.instr_valid    = (state == S_HOLD);
  assign bus.Instr          = held.instr;
  assign bus.instr_pc       = held.pc;
  assign bus.misaligned     = mis;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level reference model.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if bus ();
  instr_fetch_if bus1 ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int checks = 0;
  int errors = 0;

  // Reference model: next fetch address, whether a word is held for decode,
  // whether a request is in flight and whether its reply is already stale.
  logic [31:0] m_pc, m_instr, m_ipc;
  bit          m_held, m_pending, m_stale, m_mis;

  // Memory responder state
  bit          auto_mem, spur_en, data_rand, mem_out;
  int          mem_cnt, mem_lat;
  logic [31:0] mem_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
    m_held = 0; m_pending = 0; m_stale = 0; m_mis = 0;
    mem_out = 0; mem_cnt = 0;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    bit accept;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tgt    = bus.redirect_pc & ~32'h3;
    accept = !m_held && !m_pending && bus.imem_req_ready;
    m_mis  = bus.redirect_valid && (bus.redirect_pc % 4 != 0);
    if (m_held) begin
      if (bus.redirect_valid) begin m_held = 0; m_pc = tgt; end
      else if (bus.instr_ready) m_held = 0;
    end else if (m_pending) begin
      if (bus.imem_rsp_valid) begin
        m_pending = 0;
        if (bus.redirect_valid) m_pc = tgt;
        else if (!m_stale) begin
          m_instr = bus.imem_rsp_data; m_ipc = m_pc; m_pc = m_pc + 4; m_held = 1;
        end
      end else if (bus.redirect_valid) begin
        m_stale = 1; m_pc = tgt;
      end
    end else begin
      if (bus.redirect_valid) m_pc = tgt;
      if (bus.imem_req_ready) begin m_pending = 1; m_stale = bus.redirect_valid; end
    end
    if (accept) begin mem_out = 1; mem_cnt = mem_lat; end
  endtask

  task automatic compare_all();
    chk("req_valid", 32'(bus.imem_req_valid), 32'(rst_n && !m_held && !m_pending));
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("instr_valid", 32'(bus.instr_valid), 32'(m_held));
    chk("Instr", bus.Instr, m_instr);
    chk("instr_pc", bus.instr_pc, m_ipc);
    chk("misaligned", 32'(bus.misaligned), 32'(m_mis));
  endtask

  task automatic drive_mem();
    if (mem_out && mem_cnt == 0) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = data_rand ? $urandom : mem_word;
      mem_out = 0;
    end else begin
      bus.imem_rsp_valid = spur_en && !mem_out && !m_pending && ($urandom_range(0, 5) == 0);
      bus.imem_rsp_data  = $urandom;
      if (mem_out) mem_cnt--;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    if (auto_mem) drive_mem();
  endtask

  task automatic wait_held(input string tag);
    int n = 0;
    while (bus.instr_valid !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    chk(tag, 32'(n < 20), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          vcyc[$];
    logic [31:0] vpc[$];

    bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = 0;
    bus.redirect_valid = 0; bus.redirect_pc = 0; bus.instr_ready = 0;
    bus1.imem_req_ready = 0; bus1.imem_rsp_valid = 0; bus1.imem_rsp_data = 0;
    bus1.redirect_valid = 0; bus1.redirect_pc = 0; bus1.instr_ready = 0;
    auto_mem = 0; spur_en = 0; data_rand = 0; mem_lat = 0; mem_word = 32'h0000_0013;
    model_reset();

    // Reset values, then first request right after release
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    #1;
    chk("first_req", 32'(bus.imem_req_valid), 32'd1);
    chk("first_addr", bus.imem_addr, 32'h0);

    // Zero-wait memory, decode always ready: one instruction every 3 cycles
    bus.imem_req_ready = 1; bus.instr_ready = 1; auto_mem = 1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (bus.instr_valid === 1'b1) begin
        vcyc.push_back(i);
        vpc.push_back(bus.instr_pc);
      end
    end
    chk("stream_count", 32'(vpc.size()), 32'd4);
    if (vpc.size() >= 3) begin
      chk("stream_first_cycle", 32'(vcyc[0]), 32'd1);
      chk("stream_pc0", vpc[0], 32'h0);
      chk("stream_pc1", vpc[1], 32'h4);
      chk("stream_pc2", vpc[2], 32'h8);
      chk("stream_gap1", 32'(vcyc[1] - vcyc[0]), 32'd3);
      chk("stream_gap2", 32'(vcyc[2] - vcyc[1]), 32'd3);
    end

    // Decode stalls for 5 cycles: held word stable, no new request
    bus.instr_ready = 0;
    wait_held("hold_wait");
    repeat (5) begin
      cycle();
      chk("hold_instr", bus.Instr, 32'h0000_0013);
      chk("hold_pc", bus.instr_pc, 32'h10);
      chk("hold_no_req", 32'(bus.imem_req_valid), 32'd0);
    end
    bus.instr_ready = 1;
    cycle();
    chk("release_req", 32'(bus.imem_req_valid), 32'd1);
    chk("release_addr", bus.imem_addr, 32'h14);

    // Redirect while waiting; stale reply arrives two cycles later
    auto_mem = 0; bus.imem_rsp_valid = 0;
    cycle();
    chk("wait_no_req", 32'(bus.imem_req_valid), 32'd0);
    bus.redirect_valid = 1; bus.redirect_pc = 32'h100;
    cycle();
    bus.redirect_valid = 0;
    cycle();
    bus.imem_rsp_valid = 1; bus.imem_rsp_data = 32'hDEAD_BEEF;
    cycle();
    bus.imem_rsp_valid = 0;
    chk("drop_req", 32'(bus.imem_req_valid), 32'd1);
    chk("drop_addr", bus.imem_addr, 32'h100);
    chk("drop_no_valid", 32'(bus.instr_valid), 32'd0);
    bus.instr_ready = 0; mem_out = 0; auto_mem = 1;
    wait_held("redir_wait");
    chk("redir_pc", bus.instr_pc, 32'h100);
    chk("redir_instr", bus.Instr, 32'h0000_0013);

    // Misaligned redirect while holding with decode ready
    bus.instr_ready = 1; bus.redirect_valid = 1; bus.redirect_pc = 32'h202;
    cycle();
    bus.redirect_valid = 0; bus.instr_ready = 0;
    chk("mis_pulse", 32'(bus.misaligned), 32'd1);
    chk("mis_addr", bus.imem_addr, 32'h200);
    chk("mis_dropped", 32'(bus.instr_valid), 32'd0);
    cycle();
    chk("mis_once", 32'(bus.misaligned), 32'd0);
    wait_held("mis_wait");
    chk("mis_pc", bus.instr_pc, 32'h200);

    // Asynchronous reset during an outstanding fetch
    auto_mem = 0; bus.instr_ready = 1;
    cycle();
    bus.instr_ready = 0;
    cycle();
    chk("pre_rst_wait", 32'(bus.imem_req_valid), 32'd0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_req_low", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    bus.imem_rsp_valid = 1; bus.imem_rsp_data = 32'hBAD0_BAD0;
    @(posedge clk);
    @(negedge clk);
    compare_all();
    chk("rst_no_capture", bus.Instr, 32'h0);
    bus.imem_rsp_valid = 0;
    rst_n = 1'b1;
    #1;
    chk("rel_req", 32'(bus.imem_req_valid), 32'd1);
    chk("rel_addr", bus.imem_addr, 32'h0);
    chk("rel_valid", 32'(bus.instr_valid), 32'd0);

    // Randomized traffic against the reference model
    auto_mem = 1; spur_en = 1; data_rand = 1;
    for (int i = 0; i < 500; i++) begin
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      bus.instr_ready    = 1'($urandom_range(0, 1));
      bus.redirect_valid = ($urandom_range(0, 7) == 0);
      bus.redirect_pc    = $urandom;
      mem_lat            = $urandom_range(0, 2);
      cycle();
    end
    auto_mem = 0; spur_en = 0;
    bus.imem_rsp_valid = 0; bus.redirect_valid = 0;
    bus.imem_req_ready = 0; bus.instr_ready = 0;

    // PC wrap from the top of the address space
    chk("wrap_start", bus1.imem_addr, 32'hFFFF_FFFC);
    bus1.imem_req_ready = 1;
    cycle();
    bus1.imem_req_ready = 0;
    bus1.imem_rsp_valid = 1; bus1.imem_rsp_data = 32'h0000_0013;
    cycle();
    bus1.imem_rsp_valid = 0;
    chk("wrap_valid", 32'(bus1.instr_valid), 32'd1);
    chk("wrap_ipc", bus1.instr_pc, 32'hFFFF_FFFC);
    chk("wrap_next", bus1.imem_addr, 32'h0);
    bus1.instr_ready = 1;
    cycle();
    chk("wrap_req", 32'(bus1.imem_req_valid), 32'd1);
    chk("wrap_req_addr", bus1.imem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
